// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: exhaustive on-chip sweep of a DKNF/DDNF pair against
// a synchronous truth-table ROM, with a mismatch count and first-failure capture.
//
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   start           : sweep request, honoured only in IDLE or DONE
//   o_x, o_tbl_addr : vector driven to both implementations and the ROM
//   i_tbl_data      : ROM word, valid one cycle after its address
//   i_y_dknf/ddnf   : implementation outputs, combinational in o_x
//   busy, done, pass: sweep status
//   err_count       : vectors with any mismatch this sweep
//   first_err_*     : address and {dknf_bad, ddnf_bad} of the first mismatch
module truth_table_sweeper #(
    parameter int N_IN  = 9,
    parameter int N_OUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   o_x,
    output logic [N_IN-1:0]   o_tbl_addr,
    input  logic [0:N_OUT-1]  i_tbl_data,
    input  logic [0:N_OUT-1]  i_y_dknf,
    input  logic [0:N_OUT-1]  i_y_ddnf,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic              first_err_valid,
    output logic [N_IN-1:0]   first_err_addr,
    output logic [1:0]        first_err_kind
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [N_IN-1:0] CNT_MAX = '1;
    localparam logic [N_IN:0]   ERR_ONE = 1;

    state_t             r_state;
    state_t             w_next;
    logic [N_IN-1:0]    r_cnt;

    // Stage 1: registered implementation outputs, aligned with the ROM word
    logic               r_v1;
    logic [N_IN-1:0]    r_a1;
    logic [0:N_OUT-1]   r_y_dknf;
    logic [0:N_OUT-1]   r_y_ddnf;

    logic [N_IN:0]      r_err;
    logic               r_fev;
    logic [N_IN-1:0]    r_faddr;
    logic [1:0]         r_fkind;

    logic               w_clear;
    logic               w_dknf_bad;
    logic               w_ddnf_bad;
    logic               w_commit;
    logic               w_busy;
    logic               w_done;

    // Start is accepted only while no sweep is in flight
    assign w_clear = start && (r_state == S_IDLE || r_state == S_DONE);

    // Both compares run every vector so one failure never hides the other
    assign w_dknf_bad = r_v1 && (r_y_dknf != i_tbl_data);
    assign w_ddnf_bad = r_v1 && (r_y_ddnf != i_tbl_data);
    assign w_commit   = w_dknf_bad || w_ddnf_bad;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_SWEEP;
            S_SWEEP: if (r_cnt == CNT_MAX) w_next = S_DRAIN;
            S_DRAIN: w_next = S_DONE;
            S_DONE:  if (start) w_next = S_SWEEP;
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        unique case (r_state)
            S_SWEEP: w_busy = 1'b1;
            S_DRAIN: w_busy = 1'b1;
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    // Vector counter holds at the last vector until the next start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_clear) begin
            r_cnt <= '0;
        end else if (r_state == S_SWEEP && r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Compare pipeline; valid only for vectors presented in SWEEP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1     <= 1'b0;
            r_a1     <= '0;
            r_y_dknf <= '0;
            r_y_ddnf <= '0;
        end else begin
            r_v1     <= (r_state == S_SWEEP);
            r_a1     <= r_cnt;
            r_y_dknf <= i_y_dknf;
            r_y_ddnf <= i_y_ddnf;
        end
    end

    // Result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err   <= '0;
            r_fev   <= 1'b0;
            r_faddr <= '0;
            r_fkind <= '0;
        end else if (w_clear) begin
            r_err   <= '0;
            r_fev   <= 1'b0;
            r_faddr <= '0;
            r_fkind <= '0;
        end else if (w_commit) begin
            r_err <= r_err + ERR_ONE;
            if (!r_fev) begin
                r_fev   <= 1'b1;
                r_faddr <= r_a1;
                r_fkind <= {w_dknf_bad, w_ddnf_bad};
            end
        end
    end

    assign o_x             = r_cnt;
    assign o_tbl_addr      = r_cnt;
    assign busy            = w_busy;
    assign done            = w_done;
    assign pass            = w_done && (r_err == '0);
    assign err_count       = r_err;
    assign first_err_valid = r_fev;
    assign first_err_addr  = r_faddr;
    assign first_err_kind  = r_fkind;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed sweeps with injected implementation faults.
// The ROM and both implementations are modelled here from one table function.
module tb_truth_table_sweeper;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [8:0]   o_x;
    logic [8:0]   o_tbl_addr;
    logic [0:3]   tbl_data;
    logic [0:3]   y_dknf;
    logic [0:3]   y_ddnf;
    logic         busy;
    logic         done;
    logic         pass;
    logic [9:0]   err_count;
    logic         first_err_valid;
    logic [8:0]   first_err_addr;
    logic [1:0]   first_err_kind;

    logic [511:0] bad_k = '0;
    logic [511:0] bad_d = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [3:0] f(input logic [8:0] x);
        return (x[3:0] ^ x[7:4]) + {3'b000, x[8]};
    endfunction

    always @(posedge clk) tbl_data <= f(o_tbl_addr);

    assign y_dknf = f(o_x) ^ (bad_k[o_x] ? 4'h1 : 4'h0);
    assign y_ddnf = f(o_x) ^ (bad_d[o_x] ? 4'h8 : 4'h0);

    truth_table_sweeper #(.N_IN(9), .N_OUT(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .o_x             (o_x),
        .o_tbl_addr      (o_tbl_addr),
        .i_tbl_data      (tbl_data),
        .i_y_dknf        (y_dknf),
        .i_y_ddnf        (y_ddnf),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_err_valid (first_err_valid),
        .first_err_addr  (first_err_addr),
        .first_err_kind  (first_err_kind)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse start, then follow the sweep edge by edge. mid_start re-pulses
    // start once o_x reaches that value; rst_at resets there and aborts.
    task automatic run_sweep(input int mid_start, input int rst_at,
                             input int exp_err_512);
        bit steps_ok;
        int exp_x;
        steps_ok = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("edge0_state", {busy, done, first_err_valid, err_count},
            {1'b1, 1'b0, 1'b0, 10'd0});
        if (o_x != 0) steps_ok = 1'b0;
        for (int k = 1; k <= 513; k++) begin
            if (k - 1 == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_zero", {o_x, o_tbl_addr, busy, done, pass, err_count,
                                 first_err_valid, first_err_addr,
                                 first_err_kind}, 32'd0);
                @(posedge clk);
                #1;
                chk("rst_hold", {busy, done, o_x}, 32'd0);
                rst = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            exp_x = (k < 511) ? k : 511;
            if (o_x != exp_x[8:0] || o_tbl_addr != o_x) steps_ok = 1'b0;
            if (k == mid_start) start = 1'b1;
            if (k == 512) begin
                chk("e512_busy", {busy, done}, 2'b10);
                chk("e512_err", err_count, exp_err_512);
            end
        end
        chk("steps", steps_ok, 1);
        chk("e513_done", {busy, done}, 2'b01);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {o_x, o_tbl_addr, busy, done, pass, err_count,
                            first_err_valid, first_err_addr, first_err_kind},
            32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Clean sweep
        run_sweep(-1, -1, 0);
        chk("clean_err", err_count, 0);
        chk("clean_pass", pass, 1);
        chk("clean_fev", first_err_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("done_hold", {done, o_x}, {1'b1, 9'h1FF});

        // DDNF wrong at 0A5 only
        bad_d[9'h0A5] = 1'b1;
        run_sweep(-1, -1, 1);
        chk("d_err", err_count, 1);
        chk("d_addr", first_err_addr, 9'h0A5);
        chk("d_kind", first_err_kind, 2'b01);
        chk("d_pass", pass, 0);
        chk("d_fev", first_err_valid, 1);
        bad_d = '0;

        // Both wrong at 3, DKNF wrong at 1FF (committed at edge 513)
        bad_k[3] = 1'b1;
        bad_d[3] = 1'b1;
        bad_k[9'h1FF] = 1'b1;
        run_sweep(-1, -1, 1);
        chk("b_err", err_count, 2);
        chk("b_addr", first_err_addr, 9'd3);
        chk("b_kind", first_err_kind, 2'b11);
        bad_k = '0;
        bad_d = '0;

        // Reset mid-sweep, then a fresh clean sweep
        bad_d[9'h010] = 1'b1;
        run_sweep(-1, 100, 0);
        bad_d = '0;
        run_sweep(-1, -1, 0);
        chk("r_err", err_count, 0);
        chk("r_pass", pass, 1);

        // Start during SWEEP is ignored; restart from DONE clears
        bad_d[9'h0A5] = 1'b1;
        run_sweep(50, -1, 1);
        chk("m_err", err_count, 1);
        chk("m_addr", first_err_addr, 9'h0A5);
        run_sweep(-1, -1, 1);
        chk("m2_err", err_count, 1);
        chk("m2_kind", first_err_kind, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Synthesizable exhaustive-sweep checker for the generated DDNF/DKNF truth-table implementations. It sits directly upstream and downstream of the pair. It drives every input vector 0..2^N_IN-1 into both implementations, reads the expected output word from a synchronous table ROM holding the same truth table, and compares both implementations against it. It accumulates a mismatch count and captures the first failing vector, so a sweep can run on silicon or FPGA without a simulation host.

## Interface
Parameters:
- N_IN, default 9: number of function inputs; the sweep covers 2^N_IN vectors.
- N_OUT, default 4: number of function outputs.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; honoured only in IDLE or DONE.
- o_x  out  N_IN  vector driven to both implementations.
- o_tbl_addr  out  N_IN  table ROM address; always equal to o_x.
- i_tbl_data  in  [0:N_OUT-1]  ROM word; valid one cycle after its address.
- i_y_dknf  in  [0:N_OUT-1]  DKNF implementation output; combinational in o_x.
- i_y_ddnf  in  [0:N_OUT-1]  DDNF implementation output; combinational in o_x.
- busy  out  1  high in SWEEP and DRAIN.
- done  out  1  high in DONE.
- pass  out  1  done && err_count==0.
- err_count  out  N_IN+1  number of vectors with any mismatch; the width holds 2^N_IN, so no saturation.
- first_err_valid  out  1  a mismatch has been captured this sweep.
- first_err_addr  out  N_IN  vector of the first mismatch.
- first_err_kind  out  2  {dknf_bad, ddnf_bad} for the first mismatch.

## Operation
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE or DONE, start=1:
  - go to SWEEP.
  - cnt <= 0.
  - Clear err_count, first_err_valid, first_err_addr and first_err_kind.
- SWEEP:
  - o_x = o_tbl_addr = cnt; cnt increments by 1 per cycle.
  - When cnt == 2^N_IN-1, go to DRAIN; cnt holds (no wrap).
- DRAIN: one cycle to flush the compare pipeline, then go to DONE.
- DONE: hold all results until start or rst.
- start is ignored in SWEEP and DRAIN.
- Pipeline:
  - Stage 0: vector presented.
  - Stage 1: y_dknf_q and y_ddnf_q register the implementation outputs; the ROM word arrives.
  - Stage 2: compare and commit.
- Compare:
  - dknf_bad = y_dknf_q != i_tbl_data; ddnf_bad = y_ddnf_q != i_tbl_data.
  - Both are evaluated every vector; a DKNF failure does not mask a DDNF failure.
- Commit on (dknf_bad|ddnf_bad):
  - err_count += 1; one count per vector, even if both implementations fail.
  - If !first_err_valid, capture the stage-1 address into first_err_addr, capture {dknf_bad, ddnf_bad} into first_err_kind, and set first_err_valid.
- A stage-1 valid bit gates commits, so no compare commits in IDLE or DONE.

## Timing
- Edge 0 is the edge sampling start. Vector a is presented during cycle a and committed at edge a+2.
- Last vector: presented in cycle 2^N_IN-1, committed at edge 2^N_IN+1.
- At that same edge the state enters DONE: done=1, busy=0, and pass is valid the same cycle.
- A full sweep takes 2^N_IN+1 cycles from start (513 for N_IN=9).
- After the sweep, o_x and o_tbl_addr hold 2^N_IN-1 until restart.
- Reset values: o_x=0, o_tbl_addr=0, busy=0, done=0, pass=0, err_count=0, first_err_valid=0, first_err_addr=0, first_err_kind=0, state IDLE, pipeline valid bits 0.
- rst mid-sweep: everything returns to the reset values immediately, with no partial commit. The next start runs a full fresh sweep.
- Restart from DONE: results clear at edge 0; busy=1 from edge 0.

## Test plan
- Both implementations and the ROM carry an identical 9→4 table; pulse start.
  - Required: o_x steps 0..511 one per cycle; done rises at edge 513; err_count=0; pass=1; first_err_valid=0.
- Force DDNF output wrong at x=9'h0A5 only.
  - Required: err_count=1; first_err_addr=9'h0A5; first_err_kind=2'b01; pass=0.
- Force both implementations wrong at x=3, and DKNF wrong at x=9'h1FF.
  - Required: err_count=2; first_err_addr=3; first_err_kind=2'b11.
  - Required: the commit for 9'h1FF occurs at edge 513, in the same cycle done rises.
- Assert rst at cnt=100; release; pulse start.
  - Required: during rst, all outputs are 0 and state is IDLE.
  - Required: the new sweep starts at 0 and completes at edge 513 with fresh counts.
- Pulse start at cnt=50 during SWEEP; then, after DONE with err_count=1, pulse start again.
  - Required: the first pulse is ignored.
  - Required: the second pulse clears err_count and first_err_valid at edge 0, and the sweep reruns.
